// File: rtl/hash_request_scheduler.sv
// -----------------------------------------------------------------------------
// hash_request_scheduler
//
// Shares one fixed-latency hash-table pipeline between NUM_REQ requesters.
// One requester is granted per cycle in round-robin order. Its operation is
// registered into the pipeline, and a tag delay line matched to PIPE_LATENCY
// routes each pipeline response back to the requester that issued it. A
// flush FSM stops new grants and waits until every in-flight operation has
// retired, so a table clear or reconfiguration can run safely.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   clk_en              global stall; 0 freezes all state and handshakes
//   req_valid_i         per-requester request valid
//   req_ready_o         per-requester accept (one-hot or zero)
//   req_op_i            per-requester op (00 lookup, 01 insert, 10 delete)
//   req_key_i           per-requester key
//   req_data_i          per-requester data
//   req_hash_adr_i      per-requester hash address
//   pipe_*_o            registered issue towards the pipeline
//   pipe_resp_*_i       pipeline response (strobe, hit flag, data)
//   resp_valid_o        one-hot response strobe to the owning requester
//   resp_found_o        broadcast hit flag
//   resp_data_o         broadcast response data
//   flush_i             drain request (level)
//   flush_done_o        pipeline empty and grants stopped
//   err_o               sticky response/tag mismatch
// -----------------------------------------------------------------------------
module hash_request_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 4,
  parameter int KEY_WIDTH      = 2,
  parameter int HASH_ADR_WIDTH = 2,
  parameter int PIPE_LATENCY   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [2*NUM_REQ-1:0]              req_op_i,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]      req_key_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]     req_data_i,
  input  logic [HASH_ADR_WIDTH*NUM_REQ-1:0] req_hash_adr_i,
  output logic                              pipe_valid_o,
  output logic [1:0]                        pipe_op_o,
  output logic [KEY_WIDTH-1:0]              pipe_key_o,
  output logic [DATA_WIDTH-1:0]             pipe_data_o,
  output logic [HASH_ADR_WIDTH-1:0]         pipe_hash_adr_o,
  input  logic                              pipe_resp_valid_i,
  input  logic                              pipe_resp_found_i,
  input  logic [DATA_WIDTH-1:0]             pipe_resp_data_i,
  output logic [NUM_REQ-1:0]                resp_valid_o,
  output logic                              resp_found_o,
  output logic [DATA_WIDTH-1:0]             resp_data_o,
  input  logic                              flush_i,
  output logic                              flush_done_o,
  output logic                              err_o
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // inflight spans 0..PIPE_LATENCY+1 (issue register plus every tag stage)
  localparam int INF_W = $clog2(PIPE_LATENCY + 2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e                            state_q;
  logic                              flush_done_q;
  logic [ID_W-1:0]                   rr_ptr_q;
  logic [ID_W-1:0]                   rr_ptr_d;
  logic [ID_W:0]                     cand_s;
  logic [ID_W:0]                     idx_s;
  logic                              take_s;
  logic                              grant_found_s;
  logic [ID_W-1:0]                   grant_id_s;
  logic                              accept_s;
  logic                              transfer_s;
  logic                              pipe_valid_q;
  logic [1:0]                        pipe_op_q;
  logic [KEY_WIDTH-1:0]              pipe_key_q;
  logic [DATA_WIDTH-1:0]             pipe_data_q;
  logic [HASH_ADR_WIDTH-1:0]         pipe_hash_adr_q;
  logic [ID_W-1:0]                   pipe_id_q;
  logic [PIPE_LATENCY-1:0]           tag_valid_q;
  logic [PIPE_LATENCY-1:0][ID_W-1:0] tag_id_q;
  logic                              tail_valid_s;
  logic [ID_W-1:0]                   tail_id_s;
  logic [INF_W-1:0]                  inflight_q;
  logic [INF_W-1:0]                  inflight_d;
  logic                              err_q;

  // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    idx_s         = '0;
    take_s        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s        = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      idx_s         = (cand_s >= (ID_W+1)'(NUM_REQ)) ? (cand_s - (ID_W+1)'(NUM_REQ)) : cand_s;
      take_s        = ~grant_found_s & req_valid_i[idx_s[ID_W-1:0]];
      grant_id_s    = take_s ? idx_s[ID_W-1:0] : grant_id_s;
      grant_found_s = grant_found_s | take_s;
    end
  end

  // Reset is folded into accept so no ready is offered while reset is held.
  assign accept_s    = clk_en & (state_q == ST_RUN) & ~flush_i & ~reset;
  assign transfer_s  = accept_s & grant_found_s;
  assign req_ready_o = transfer_s ? (NUM_REQ'(1'b1) << grant_id_s) : '0;
  assign rr_ptr_d    = (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : (grant_id_s + ID_W'(1));

  assign tail_valid_s = tag_valid_q[PIPE_LATENCY-1];
  assign tail_id_s    = tag_id_q[PIPE_LATENCY-1];

  assign resp_valid_o = (tail_valid_s & pipe_resp_valid_i & clk_en) ?
                        (NUM_REQ'(1'b1) << tail_id_s) : '0;
  assign resp_found_o = pipe_resp_found_i;
  assign resp_data_o  = pipe_resp_data_i;

  assign pipe_valid_o    = pipe_valid_q;
  assign pipe_op_o       = pipe_op_q;
  assign pipe_key_o      = pipe_key_q;
  assign pipe_data_o     = pipe_data_q;
  assign pipe_hash_adr_o = pipe_hash_adr_q;
  assign flush_done_o    = flush_done_q;
  assign err_o           = err_q;

  // In-flight count: +1 per grant, -1 per tag leaving the delay line.
  always_comb begin
    inflight_d = inflight_q;
    case ({transfer_s, tail_valid_s})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Issue register, round-robin pointer, tag delay line, inflight and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_q    <= 1'b0;
      pipe_op_q       <= 2'b00;
      pipe_key_q      <= '0;
      pipe_data_q     <= '0;
      pipe_hash_adr_q <= '0;
      pipe_id_q       <= '0;
      rr_ptr_q        <= '0;
      tag_valid_q     <= '0;
      tag_id_q        <= '0;
      inflight_q      <= '0;
      err_q           <= 1'b0;
    end else if (clk_en) begin
      pipe_valid_q <= transfer_s;
      if (transfer_s) begin
        pipe_op_q       <= req_op_i[grant_id_s*2 +: 2];
        pipe_key_q      <= req_key_i[grant_id_s*KEY_WIDTH +: KEY_WIDTH];
        pipe_data_q     <= req_data_i[grant_id_s*DATA_WIDTH +: DATA_WIDTH];
        pipe_hash_adr_q <= req_hash_adr_i[grant_id_s*HASH_ADR_WIDTH +: HASH_ADR_WIDTH];
        pipe_id_q       <= grant_id_s;
        rr_ptr_q        <= rr_ptr_d;
      end
      // tag[0] captures the issue register, so the tail lines up with the
      // response PIPE_LATENCY enabled cycles after pipe_valid_o.
      tag_valid_q[0] <= pipe_valid_q;
      tag_id_q[0]    <= pipe_id_q;
      for (int k = 1; k < PIPE_LATENCY; k++) begin
        tag_valid_q[k] <= tag_valid_q[k-1];
        tag_id_q[k]    <= tag_id_q[k-1];
      end
      inflight_q <= inflight_d;
      if (tail_valid_s ^ pipe_resp_valid_i) begin
        err_q <= 1'b1;
      end
    end
  end

  // Flush FSM; flush_done is registered alongside the DONE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else if (clk_en) begin
      case (state_q)
        ST_RUN: begin
          if (flush_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // flush_i is ignored here: draining always completes first
          if (inflight_q == '0) begin
            state_q      <= ST_DONE;
            flush_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!flush_i) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_request_scheduler.sv
module tb_hash_request_scheduler;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int KW = 2;
  localparam int HW = 2;
  localparam int L  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            clk_en;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [2*N-1:0]  req_op_i;
  logic [KW*N-1:0] req_key_i;
  logic [DW*N-1:0] req_data_i;
  logic [HW*N-1:0] req_hash_adr_i;
  logic            pipe_valid_o;
  logic [1:0]      pipe_op_o;
  logic [KW-1:0]   pipe_key_o;
  logic [DW-1:0]   pipe_data_o;
  logic [HW-1:0]   pipe_hash_adr_o;
  logic            pipe_resp_valid_i;
  logic            pipe_resp_found_i;
  logic [DW-1:0]   pipe_resp_data_i;
  logic [N-1:0]    resp_valid_o;
  logic            resp_found_o;
  logic [DW-1:0]   resp_data_o;
  logic            flush_i;
  logic            flush_done_o;
  logic            err_o;

  hash_request_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .KEY_WIDTH(KW), .HASH_ADR_WIDTH(HW), .PIPE_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_key_i(req_key_i), .req_data_i(req_data_i), .req_hash_adr_i(req_hash_adr_i),
    .pipe_valid_o(pipe_valid_o), .pipe_op_o(pipe_op_o), .pipe_key_o(pipe_key_o),
    .pipe_data_o(pipe_data_o), .pipe_hash_adr_o(pipe_hash_adr_o),
    .pipe_resp_valid_i(pipe_resp_valid_i), .pipe_resp_found_i(pipe_resp_found_i),
    .pipe_resp_data_i(pipe_resp_data_i), .resp_valid_o(resp_valid_o),
    .resp_found_o(resp_found_o), .resp_data_o(resp_data_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Scoreboard entries: granted-but-not-issued ops, and issued ops awaiting response.
  typedef struct {
    int            id;
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [DW-1:0] data;
    logic [HW-1:0] hash;
  } iss_t;

  typedef struct {
    int            id;
    int            due;
    logic          found;
    logic [DW-1:0] data;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t pend_q[$];

  int m_rr;      // next requester to favour
  int m_state;   // 0 RUN, 1 DRAIN, 2 DONE
  bit m_err;
  int en_cnt;    // enabled clock edges seen so far
  bit mon_en;
  bit inject_bad;
  bit fl;
  int checks;
  int failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs mid-cycle, then advances the reference model
  // across the coming clock edge.
  always @(negedge clk) begin
    int gi;
    int cand;
    int outstanding;
    bit acc;
    bit tail;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_resp;
    iss_t it;
    rsp_t rp;
    if (mon_en && !reset) begin
      acc = clk_en && (m_state == 0) && !flush_i;
      gi = -1;
      for (int k = 0; k < N; k++) begin
        cand = (m_rr + k) % N;
        if (gi < 0 && req_valid_i[cand]) gi = cand;
      end
      exp_ready = '0;
      if (acc && gi >= 0) exp_ready[gi] = 1'b1;
      chk("req_ready", 64'(req_ready_o), 64'(exp_ready));

      chk("pipe_valid", 64'(pipe_valid_o), 64'(iss_q.size() != 0));
      if (iss_q.size() != 0)
        chk("pipe_fields", 64'({pipe_op_o, pipe_key_o, pipe_data_o, pipe_hash_adr_o}),
            64'({iss_q[0].op, iss_q[0].key, iss_q[0].data, iss_q[0].hash}));

      tail = (pend_q.size() != 0) && (pend_q[0].due == en_cnt);
      exp_resp = '0;
      if (clk_en && tail) exp_resp[pend_q[0].id] = 1'b1;
      chk("resp_valid", 64'(resp_valid_o), 64'(exp_resp));
      if (clk_en && tail)
        chk("resp_payload", 64'({resp_found_o, resp_data_o}),
            64'({pend_q[0].found, pend_q[0].data}));

      chk("flush_done", 64'(flush_done_o), 64'(m_state == 2));
      chk("err", 64'(err_o), 64'(m_err));

      outstanding = iss_q.size() + pend_q.size();
      if (clk_en) begin
        if (tail != pipe_resp_valid_i) m_err = 1'b1;
        if (tail) void'(pend_q.pop_front());
        if (iss_q.size() != 0) begin
          it       = iss_q.pop_front();
          rp.id    = it.id;
          rp.due   = en_cnt + L;
          rp.found = 1'($urandom);
          rp.data  = DW'($urandom);
          pend_q.push_back(rp);
        end
        if (acc && gi >= 0) begin
          it.id   = gi;
          it.op   = req_op_i[2*gi +: 2];
          it.key  = req_key_i[KW*gi +: KW];
          it.data = req_data_i[DW*gi +: DW];
          it.hash = req_hash_adr_i[HW*gi +: HW];
          iss_q.push_back(it);
          m_rr = (gi + 1) % N;
        end
        case (m_state)
          0:       if (flush_i) m_state = 1;
          1:       if (outstanding == 0) m_state = 2;
          default: if (!flush_i) m_state = 0;
        endcase
        en_cnt++;
      end
    end
  end

  // Pipeline model: answers each issued op after L enabled cycles.
  always @(posedge clk) begin
    #2;
    if (pend_q.size() != 0 && pend_q[0].due == en_cnt) begin
      pipe_resp_valid_i = 1'b1;
      pipe_resp_found_i = pend_q[0].found;
      pipe_resp_data_i  = pend_q[0].data;
    end else begin
      pipe_resp_valid_i = inject_bad;
      pipe_resp_found_i = 1'($urandom);
      pipe_resp_data_i  = DW'($urandom);
    end
  end

  task automatic cyc(input logic [N-1:0] v, input bit fl_in, input bit en);
    req_valid_i    = v;
    req_op_i       = (2*N)'($urandom);
    req_key_i      = (KW*N)'($urandom);
    req_data_i     = (DW*N)'($urandom);
    req_hash_adr_i = (HW*N)'($urandom);
    flush_i        = fl_in;
    clk_en         = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'h0);
    chk({tag, "_pipe"}, 64'({pipe_valid_o, pipe_op_o, pipe_key_o, pipe_data_o, pipe_hash_adr_o}), 64'h0);
    chk({tag, "_resp"}, 64'({resp_valid_o, resp_found_o, resp_data_o}), 64'h0);
    chk({tag, "_done_err"}, 64'({flush_done_o, err_o}), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    m_rr = 0; m_state = 0; m_err = 1'b0; en_cnt = 0;
    mon_en = 1'b0; inject_bad = 1'b0; fl = 1'b0;
    reset = 1'b1; clk_en = 1'b1; flush_i = 1'b0;
    req_valid_i = '1; req_op_i = '0; req_key_i = '0; req_data_i = '0; req_hash_adr_i = '0;
    pipe_resp_valid_i = 1'b0; pipe_resp_found_i = 1'b0; pipe_resp_data_i = '0;
    repeat (2) @(posedge clk);
    #3;
    pipe_resp_found_i = 1'b0; pipe_resp_data_i = '0;
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Single requester 1 lookup, key 2 data 5
    req_valid_i = 4'b0010;
    req_op_i = '0; req_key_i = '0; req_data_i = '0; req_hash_adr_i = '0;
    req_key_i[2 +: 2] = 2'd2;
    req_data_i[4 +: 4] = 4'd5;
    flush_i = 1'b0; clk_en = 1'b1;
    @(posedge clk);
    #1;
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);

    // All requesters continuously valid
    repeat (12) cyc(4'b1111, 1'b0, 1'b1);
    repeat (5) cyc(4'b0000, 1'b0, 1'b1);

    // Randomized traffic with stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) fl = !fl;
      cyc(N'($urandom), fl, $urandom_range(0, 9) != 0);
    end
    fl = 1'b0;
    repeat (10) cyc(4'b0000, 1'b0, 1'b1);

    // Three back-to-back ops then flush, drop flush, grants resume
    repeat (3) cyc(4'b0001, 1'b0, 1'b1);
    repeat (8) cyc(4'b1111, 1'b1, 1'b1);
    repeat (6) cyc(4'b1111, 1'b0, 1'b1);
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);

    // Stall for 5 cycles with an op sitting in the issue register
    cyc(4'b0100, 1'b0, 1'b1);
    repeat (5) cyc(4'b1111, 1'b0, 1'b0);
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);

    // Spurious response with the tail empty: sticky error
    inject_bad = 1'b1;
    cyc(4'b0000, 1'b0, 1'b1);
    inject_bad = 1'b0;
    repeat (5) cyc(4'b1111, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a burst
    repeat (3) cyc(4'b1111, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    mon_en = 1'b0;
    iss_q.delete();
    pend_q.delete();
    m_rr = 0; m_state = 0; m_err = 1'b0;
    pipe_resp_valid_i = 1'b0; pipe_resp_found_i = 1'b0; pipe_resp_data_i = '0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    // Flush right after reset completes in two cycles only if inflight is zero
    repeat (4) cyc(4'b0000, 1'b1, 1'b1);
    repeat (6) cyc(4'b1111, 1'b0, 1'b1);
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hash_request_scheduler.md
Name: hash_request_scheduler

Overview:
Shares one fixed-latency hash-table pipeline between NUM_REQ requesters. Each cycle it grants one requester round-robin and registers the operation into the pipeline. It then routes each pipeline response back to the requester that issued it, using a tag delay line matched to the pipeline latency. A flush FSM drains all in-flight operations on request; this is used before table clear or reconfiguration.

Parameters:
- NUM_REQ, 4, number of requester ports (>=1)
- DATA_WIDTH, 4, data field width
- KEY_WIDTH, 2, key field width
- HASH_ADR_WIDTH, 2, hash address width
- PIPE_LATENCY, 3, clk_en cycles from pipe_valid_o to the matching pipe_resp_valid_i (>=1)
- ID_W (derived), NUM_REQ>1 ? $clog2(NUM_REQ) : 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  global stall; when 0 all state holds and no handshake completes
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept, one-hot or zero
- req_op_i  in  2*NUM_REQ  per requester: 00 lookup, 01 insert, 10 delete, 11 reserved (passed through)
- req_key_i  in  KEY_WIDTH*NUM_REQ  per-requester key
- req_data_i  in  DATA_WIDTH*NUM_REQ  per-requester data
- req_hash_adr_i  in  HASH_ADR_WIDTH*NUM_REQ  per-requester hash address
- pipe_valid_o  out  1  issue strobe to the pipeline
- pipe_op_o  out  2  issued op
- pipe_key_o  out  KEY_WIDTH  issued key
- pipe_data_o  out  DATA_WIDTH  issued data
- pipe_hash_adr_o  out  HASH_ADR_WIDTH  issued hash address
- pipe_resp_valid_i  in  1  pipeline response strobe
- pipe_resp_found_i  in  1  hit flag
- pipe_resp_data_i  in  DATA_WIDTH  response data
- resp_valid_o  out  NUM_REQ  one-hot response strobe to the owning requester
- resp_found_o  out  1  broadcast hit flag
- resp_data_o  out  DATA_WIDTH  broadcast response data
- flush_i  in  1  drain request (level)
- flush_done_o  out  1  pipeline empty and no grants
- err_o  out  1  sticky response/tag mismatch

Behaviour:
- Reset: all outputs 0, rr_ptr=0, inflight=0, tag line cleared, err_o=0, state RUN.
- accept = clk_en & (state==RUN) & ~flush_i.
- Grant: first i with req_valid_i[i]=1, searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ. req_ready_o is the one-hot of that i AND accept, so it is combinational from req_valid_i.
- Transfer occurs when valid and ready are both high; on transfer rr_ptr <= (i+1) mod NUM_REQ.
- Requesters may drop valid without a transfer.
- Issue register (when clk_en): on transfer, pipe_valid_o<=1 and the granted fields plus ID are latched; otherwise pipe_valid_o<=0. Latency from request to issue is 1 cycle.
- Tag delay line (when clk_en): tag[0] <= {pipe_valid_o, issued ID}; tag[k] <= tag[k-1]; tail = tag[PIPE_LATENCY-1].
- Response: resp_valid_o = onehot(tail.id) when tail.valid & pipe_resp_valid_i & clk_en. resp_found_o and resp_data_o are combinational pass-throughs.
- err_o is set to 1 (until reset) when clk_en & (tail.valid XOR pipe_resp_valid_i).
- inflight counter, range 0..PIPE_LATENCY+1, updated when clk_en: +1 on transfer, -1 when tail.valid; a simultaneous +1/-1 leaves it unchanged.
- FSM transitions, evaluated when clk_en:
  - RUN -> DRAIN on flush_i.
  - DRAIN -> DONE when inflight==0.
  - DONE -> RUN when flush_i==0.
  - flush_i dropping in DRAIN has no effect; draining completes first.
- flush_done_o = (state==DONE).
- clk_en=0: req_ready_o=0, resp_valid_o=0, and every register holds, including pipe_valid_o.
- Asynchronous reset mid-operation discards all in-flight tags; responses already in the pipeline are not routed.

Test Plan:
- NUM_REQ=4, PIPE_LATENCY=3, only req1 valid with key=2, data=5 -> ready[1] in cycle 0; pipe_valid_o with key=2, data=5 in cycle 1; model returns found=1 in cycle 4 -> resp_valid_o=0010, resp_data_o echoed.
- All four requesters continuously valid, rr_ptr=0 -> grants 0,1,2,3,0,… on successive cycles; each resp_valid_o one-hot lands 3 cycles after its pipe_valid_o, in the same order.
- Issue 3 back-to-back ops, then assert flush_i -> req_ready_o=0 immediately; flush_done_o rises 1 cycle after the last response; dropping flush_i returns to RUN and grants resume.
- clk_en held 0 for 5 cycles with an op in flight -> pipe_valid_o, tags, inflight and rr_ptr all frozen; the response arrives PIPE_LATENCY enabled cycles after issue.
- Inject pipe_resp_valid_i with the tail empty -> err_o=1 and it stays 1 until reset.
- Assert reset asynchronously mid-burst -> all outputs 0 immediately, state RUN, inflight=0.
